// File: rtl/picoblaze_irq_pkg.sv
// Shared types and constants for the PicoBlaze interrupt controller.
package picoblaze_irq_pkg;

  localparam int ID_W    = 3;
  localparam int MAX_SRC = 8;

  localparam logic [7:0] PORT_STATUS_DEF = 8'h01;
  localparam logic [7:0] PORT_MASK_DEF   = 8'h02;
  localparam logic [7:0] PORT_EOI_DEF    = 8'h04;
  localparam logic [7:0] PORT_OVF_DEF    = 8'h08;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ASSERT  = 2'd1,
    SERVICE = 2'd2
  } irq_state_e;

endpackage

// File: rtl/picoblaze_irq_prio_sel.sv
// Combinational find-first-set over the request vector, searching upward from
// i_start and wrapping at NUM_SRC.
module picoblaze_irq_prio_sel
  import picoblaze_irq_pkg::*;
#(
  parameter int NUM_SRC = 4
) (
  input  logic [NUM_SRC-1:0] i_req,
  input  logic [ID_W-1:0]    i_start,
  output logic [ID_W-1:0]    o_sel,
  output logic               o_valid
);

  logic [ID_W:0]        w_idx;
  logic [NUM_SRC-1:0]   w_sh;

  // Walk from the farthest candidate back to i_start so the nearest one wins.
  always_comb begin
    o_sel   = '0;
    o_valid = 1'b0;
    w_idx   = '0;
    w_sh    = '0;
    for (int k = NUM_SRC - 1; k >= 0; k--) begin
      w_idx = {1'b0, i_start} + (ID_W + 1)'(k);
      if (w_idx >= (ID_W + 1)'(NUM_SRC))
        w_idx = w_idx - (ID_W + 1)'(NUM_SRC);
      w_sh = i_req >> w_idx;
      if (w_sh[0]) begin
        o_sel   = w_idx[ID_W-1:0];
        o_valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/picoblaze_irq_controller.sv
// Multi-source interrupt controller for the PacoBlaze interrupt/ack pair.
// Define PICO_IRQ_ROUND_ROBIN_EN for rotating priority; default is lowest-index-first.
module picoblaze_irq_controller
  import picoblaze_irq_pkg::*;
#(
  parameter int                 NUM_SRC     = 4,
  parameter logic [7:0]         PORT_STATUS = PORT_STATUS_DEF,
  parameter logic [7:0]         PORT_MASK   = PORT_MASK_DEF,
  parameter logic [7:0]         PORT_EOI    = PORT_EOI_DEF,
  parameter logic [7:0]         PORT_OVF    = PORT_OVF_DEF,
  parameter logic [NUM_SRC-1:0] MASK_INIT   = {NUM_SRC{1'b1}}
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_SRC-1:0] event_in,
  output logic               interrupt,
  input  logic               interrupt_ack,
  input  logic [7:0]         port_id,
  input  logic               write_strobe,
  input  logic               read_strobe,
  input  logic [7:0]         out_port,
  output logic [7:0]         rd_data,
  output logic               irq_active
);

  irq_state_e         r_state;
  logic [NUM_SRC-1:0] r_pending;
  logic [NUM_SRC-1:0] r_ovf;
  logic [NUM_SRC-1:0] r_mask;
  logic [ID_W-1:0]    r_cur_id;

  logic [NUM_SRC-1:0] w_eligible;
  logic [NUM_SRC-1:0] w_clr;
  logic [NUM_SRC-1:0] w_ovf_set;
  logic [NUM_SRC-1:0] w_ovf_w1c;
  logic [ID_W-1:0]    w_start;
  logic [ID_W-1:0]    w_sel;
  logic               w_sel_valid;
  logic               w_ack;
  logic               w_wr_mask;
  logic               w_wr_eoi;
  logic               w_wr_ovf;
  logic [7:0]         w_rd_next;
  logic               w_unused;

  // Reads are side-effect free, so read_strobe carries no function here.
  assign w_unused = ^{read_strobe, out_port};

  assign w_eligible = r_pending & r_mask;
  assign w_ack      = (r_state == ASSERT) && interrupt_ack;
  assign w_clr      = w_ack ? (NUM_SRC'(1) << r_cur_id) : '0;
  assign w_ovf_set  = event_in & r_pending & ~w_clr;
  assign w_wr_mask  = write_strobe && (port_id == PORT_MASK);
  assign w_wr_eoi   = write_strobe && (port_id == PORT_EOI);
  assign w_wr_ovf   = write_strobe && (port_id == PORT_OVF);
  assign w_ovf_w1c  = w_wr_ovf ? out_port[NUM_SRC-1:0] : '0;

`ifdef PICO_IRQ_ROUND_ROBIN_EN
  logic [ID_W-1:0] r_last_id;

  assign w_start = (r_last_id == ID_W'(NUM_SRC - 1)) ? '0 : r_last_id + ID_W'(1);

  always_ff @(posedge clk) begin
    if (reset)
      r_last_id <= ID_W'(NUM_SRC - 1);
    else if (w_ack)
      r_last_id <= r_cur_id;
  end
`else
  assign w_start = '0;
`endif

  picoblaze_irq_prio_sel #(
    .NUM_SRC (NUM_SRC)
  ) u_prio_sel (
    .i_req   (w_eligible),
    .i_start (w_start),
    .o_sel   (w_sel),
    .o_valid (w_sel_valid)
  );

  always_comb begin
    w_rd_next = '0;
    if (port_id == PORT_STATUS)
      w_rd_next = {irq_active, |w_eligible, 3'b000, r_cur_id};
    else if (port_id == PORT_MASK)
      w_rd_next[NUM_SRC-1:0] = r_mask;
    else if (port_id == PORT_OVF)
      w_rd_next[NUM_SRC-1:0] = r_ovf;
  end

  // A new event beats both the ack-clear of pending and the W1C of overflow.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= IDLE;
      r_pending  <= '0;
      r_ovf      <= '0;
      r_mask     <= MASK_INIT;
      r_cur_id   <= '0;
      interrupt  <= 1'b0;
      irq_active <= 1'b0;
      rd_data    <= '0;
    end else begin
      r_pending <= (r_pending & ~w_clr) | event_in;
      r_ovf     <= (r_ovf & ~w_ovf_w1c) | w_ovf_set;
      rd_data   <= w_rd_next;
      if (w_wr_mask)
        r_mask <= out_port[NUM_SRC-1:0];
      case (r_state)
        IDLE: if (w_sel_valid) begin
          r_state    <= ASSERT;
          r_cur_id   <= w_sel;
          interrupt  <= 1'b1;
          irq_active <= 1'b1;
        end
        ASSERT: if (interrupt_ack) begin
          r_state   <= SERVICE;
          interrupt <= 1'b0;
        end
        SERVICE: if (w_wr_eoi) begin
          r_state    <= IDLE;
          irq_active <= 1'b0;
        end
        default: begin
          r_state    <= IDLE;
          interrupt  <= 1'b0;
          irq_active <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_picoblaze_irq_controller.sv
// Bench for picoblaze_irq_controller: directed scenarios plus random traffic,
// every cycle compared against a behavioural model of the controller.
module tb_picoblaze_irq_controller;

  localparam int NS = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic [NS-1:0] event_in;
  logic          interrupt;
  logic          interrupt_ack;
  logic [7:0]    port_id;
  logic          write_strobe;
  logic          read_strobe;
  logic [7:0]    out_port;
  logic [7:0]    rd_data;
  logic          irq_active;

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  picoblaze_irq_controller #(.NUM_SRC(NS)) dut (
    .clk           (clk),
    .reset         (reset),
    .event_in      (event_in),
    .interrupt     (interrupt),
    .interrupt_ack (interrupt_ack),
    .port_id       (port_id),
    .write_strobe  (write_strobe),
    .read_strobe   (read_strobe),
    .out_port      (out_port),
    .rd_data       (rd_data),
    .irq_active    (irq_active)
  );

  // Behavioural model: phase 0 = waiting for work, 1 = waiting for ack, 2 = in ISR
  bit [NS-1:0] m_pend, m_ovf, m_mask;
  int          m_phase, m_id, m_last;
  bit          m_int, m_act, m_live = 1'b0;
  bit [7:0]    m_rd;

  function automatic int pick(input bit [NS-1:0] e, input int start);
    bit [NS-1:0] t;
    for (int k = 0; k < NS; k++) begin
      t = e >> ((start + k) % NS);
      if (t[0]) return (start + k) % NS;
    end
    return -1;
  endfunction

  task automatic model_step();
    bit [NS-1:0] elig, np, no;
    bit [7:0]    rdv;
    bit          acked, cleared;
    int          sel, start;
    if (reset) begin
      m_pend = '0; m_ovf = '0; m_mask = '1; m_phase = 0; m_id = 0;
      m_last = NS - 1; m_int = 0; m_act = 0; m_rd = 0; m_live = 1'b1;
      return;
    end
    if (!m_live) return;
    elig = m_pend & m_mask;
    rdv  = 8'h00;
    if (port_id == 8'h01) rdv = {m_act, (elig != 0), 3'b000, 3'(m_id)};
    else if (port_id == 8'h02) rdv = 8'(m_mask);
    else if (port_id == 8'h08) rdv = 8'(m_ovf);
    acked = (m_phase == 1) && interrupt_ack;
    np = m_pend;
    no = m_ovf;
    for (int i = 0; i < NS; i++) begin
      cleared = acked && (i == m_id);
      if (write_strobe && port_id == 8'h08 && out_port[i]) no[i] = 1'b0;
      if (event_in[i] && m_pend[i] && !cleared) no[i] = 1'b1;
      if (event_in[i]) np[i] = 1'b1;
      else if (cleared) np[i] = 1'b0;
    end
`ifdef PICO_IRQ_ROUND_ROBIN_EN
    start = (m_last + 1) % NS;
`else
    start = 0;
`endif
    if (m_phase == 0) begin
      sel = pick(elig, start);
      if (sel >= 0) begin m_phase = 1; m_id = sel; m_int = 1; m_act = 1; end
    end else if (m_phase == 1) begin
      if (interrupt_ack) begin m_phase = 2; m_int = 0; m_last = m_id; end
    end else if (write_strobe && port_id == 8'h04) begin
      m_phase = 0; m_act = 0;
    end
    if (write_strobe && port_id == 8'h02) m_mask = out_port[NS-1:0];
    m_pend = np;
    m_ovf  = no;
    m_rd   = rdv;
  endtask

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  initial forever begin
    @(negedge clk);
    if (m_live) begin
      chk("interrupt", 8'(interrupt), 8'(m_int));
      chk("irq_active", 8'(irq_active), 8'(m_act));
      chk("rd_data", rd_data, m_rd);
    end
  end

  task automatic step(input bit [NS-1:0] ev, input bit ack, input bit ws,
                      input bit [7:0] pid, input bit [7:0] dat);
    event_in = ev; interrupt_ack = ack; write_strobe = ws;
    port_id = pid; out_port = dat; read_strobe = !ws && (pid != 8'h00);
    @(posedge clk); #1;
    event_in = '0; interrupt_ack = 1'b0; write_strobe = 1'b0; read_strobe = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step('0, 0, 0, 8'h00, 8'h00);
    step('0, 0, 0, 8'h00, 8'h00);
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1; event_in = '0; interrupt_ack = 1'b0; write_strobe = 1'b0;
    read_strobe = 1'b0; port_id = 8'h00; out_port = 8'h00;
    do_reset();
    chk("reset_interrupt", 8'(interrupt), 8'h00);
    chk("reset_active", 8'(irq_active), 8'h00);
    chk("reset_rd", rd_data, 8'h00);

    // Single event on source 2
    step(4'b0100, 0, 0, 8'h00, 8'h00);
    chk("t1_no_irq_yet", 8'(interrupt), 8'h00);
    step('0, 0, 0, 8'h00, 8'h00);
    chk("t1_irq_high", 8'(interrupt), 8'h01);
    step('0, 1, 0, 8'h01, 8'h00);
    chk("t1_irq_dropped", 8'(interrupt), 8'h00);
    step('0, 0, 0, 8'h01, 8'h00);
    chk("t1_status", rd_data, 8'h82);
    step('0, 0, 1, 8'h04, 8'h00);

    // Two simultaneous events, fixed priority
    do_reset();
    step(4'b1010, 0, 0, 8'h00, 8'h00);
    step('0, 0, 0, 8'h01, 8'h00);
    step('0, 0, 0, 8'h01, 8'h00);
    chk("t2_status_id1", rd_data, 8'hC1);
    step('0, 1, 0, 8'h00, 8'h00);
    step('0, 0, 1, 8'h04, 8'h00);
    step('0, 0, 0, 8'h01, 8'h00);
    chk("t2_reassert", 8'(interrupt), 8'h01);
    step('0, 0, 0, 8'h01, 8'h00);
    chk("t2_status_id3", rd_data, 8'hC3);
    step('0, 1, 0, 8'h00, 8'h00);
    step('0, 0, 1, 8'h04, 8'h00);

    // Masked source pends but is not presented
    step('0, 0, 1, 8'h02, 8'h0E);
    step(4'b0001, 0, 0, 8'h00, 8'h00);
    step('0, 0, 0, 8'h01, 8'h00);
    chk("t3_masked_status", rd_data, 8'h03);
    chk("t3_masked_noirq", 8'(interrupt), 8'h00);
    step('0, 0, 1, 8'h02, 8'h0F);
    step('0, 0, 0, 8'h02, 8'h00);
    chk("t3_unmask_irq", 8'(interrupt), 8'h01);
    chk("t3_mask_read", rd_data, 8'h0F);
    step('0, 1, 0, 8'h01, 8'h00);
    step('0, 0, 1, 8'h04, 8'h00);

    // Overflow and write-1-to-clear
    step(4'b0010, 0, 0, 8'h00, 8'h00);
    step(4'b0010, 0, 0, 8'h00, 8'h00);
    step('0, 0, 0, 8'h08, 8'h00);
    chk("t4_ovf_read", rd_data, 8'h02);
    step('0, 0, 1, 8'h08, 8'h02);
    step('0, 0, 0, 8'h08, 8'h00);
    chk("t4_ovf_cleared", rd_data, 8'h00);
    step('0, 1, 0, 8'h00, 8'h00);
    step('0, 0, 1, 8'h04, 8'h00);

    // Event coinciding with its own ack
    step(4'b0100, 0, 0, 8'h00, 8'h00);
    step('0, 0, 0, 8'h00, 8'h00);
    step(4'b0100, 1, 0, 8'h00, 8'h00);
    step('0, 0, 0, 8'h08, 8'h00);
    chk("t5_no_ovf", rd_data, 8'h00);
    step('0, 0, 0, 8'h01, 8'h00);
    chk("t5_still_pending", rd_data, 8'hC2);
    step('0, 0, 1, 8'h04, 8'h00);
    step('0, 0, 0, 8'h00, 8'h00);
    chk("t5_reassert", 8'(interrupt), 8'h01);
    step('0, 1, 0, 8'h00, 8'h00);

    // Reset while in service
    step('0, 0, 1, 8'h02, 8'h05);
    reset = 1'b1;
    step('0, 0, 0, 8'h02, 8'h00);
    reset = 1'b0;
    chk("t6_reset_irq", 8'(interrupt), 8'h00);
    step('0, 0, 0, 8'h02, 8'h00);
    chk("t6_reset_mask", rd_data, 8'h0F);
    step('0, 0, 0, 8'h01, 8'h00);
    chk("t6_reset_status", rd_data, 8'h00);

`ifdef PICO_IRQ_ROUND_ROBIN_EN
    do_reset();
    step(4'hF, 0, 0, 8'h00, 8'h00);
    for (int n = 0; n < 5; n++) begin
      step(4'hF, 0, 0, 8'h00, 8'h00);
      step(4'hF, 1, 0, 8'h01, 8'h00);
      chk("rr_order", 8'(rd_data[2:0]), 8'(n % NS));
      step(4'hF, 0, 1, 8'h04, 8'h00);
    end
`endif

    // Random traffic against the model
    for (int c = 0; c < 3000; c++) begin
      bit [NS-1:0] ev;
      bit [7:0]    pid;
      bit          ack;
      ev = '0;
      for (int i = 0; i < NS; i++) ev[i] = ($urandom_range(7) == 0);
      ack = interrupt ? ($urandom_range(2) == 0) : ($urandom_range(9) == 0);
      case ($urandom_range(5))
        0: pid = 8'h01;
        1: pid = 8'h02;
        2: pid = 8'h04;
        3: pid = 8'h08;
        default: pid = 8'($urandom);
      endcase
      reset = ($urandom_range(499) == 0);
      step(ev, ack, ($urandom_range(4) == 0), pid, 8'($urandom));
      reset = 1'b0;
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/picoblaze_irq_controller.md
Name: picoblaze_irq_controller

Overview:
Multi-source interrupt controller sitting between the design's event sources (1 Hz tick, audio sample strobe, keyboard, flash-read done, etc.) and the PacoBlaze `interrupt`/`interrupt_ack` pair. It latches event pulses into per-source pending bits and applies a mask. It presents one interrupt at a time to the processor and exposes the winning source ID, mask and overflow flags through the processor's port I/O space. The ISR reads the ID, services the source and writes an end-of-interrupt (EOI).

Parameters:
- NUM_SRC, 4: number of event sources, 1..8.
- PORT_STATUS, 8'h01: read port returning status/ID byte.
- PORT_MASK, 8'h02: read/write port for mask (1 = enabled).
- PORT_EOI, 8'h04: write port; any write ends service.
- PORT_OVF, 8'h08: read port for overflow flags; write-1-to-clear.
- MASK_INIT, {NUM_SRC{1'b1}}: mask value after reset.

Ports:
- clk, input, 1: system clock.
- reset, input, 1: synchronous, active-high reset.
- event_in, input, NUM_SRC: single-cycle event pulses, already synchronous to clk.
- interrupt, output, 1: to processor `interrupt`; registered.
- interrupt_ack, input, 1: from processor; single-cycle pulse, sampled synchronously.
- port_id, input, 8: processor port address.
- write_strobe, input, 1: processor write qualifier.
- read_strobe, input, 1: processor read qualifier (used only for the OVF-clear-on-read ban; reads have no side effects).
- out_port, input, 8: processor write data.
- rd_data, output, 8: registered read data; the top level ORs it into the `in_port` mux.
- irq_active, output, 1: high in ASSERT or SERVICE; for debug LED.

Behaviour:
- Reset values:
  - interrupt=0, rd_data=0, irq_active=0.
  - pending=0, ovf=0, mask=MASK_INIT, cur_id=0, state=IDLE.
  - Reset asserted mid-operation drops interrupt at the next edge and discards the in-flight service.
- Pending and overflow:
  - event_in[i]=1 at edge N sets pending[i] after N.
  - If pending[i] is already 1 and is not being cleared that cycle, ovf[i] is set (sticky).
  - Masked sources still pend and can overflow; they are not selected.
- Selection:
  - eligible = pending & mask.
  - Fixed priority: the lowest index wins.
  - Selection is combinational; the result is registered into cur_id on the IDLE->ASSERT transition.
- FSM states IDLE, ASSERT, SERVICE:
  - IDLE: if eligible is non-zero, go to ASSERT, interrupt<=1, latch cur_id. Latency from event edge N to interrupt high is edge N+1 (2 cycles).
  - ASSERT: on interrupt_ack, go to SERVICE, interrupt<=0, clear pending[cur_id]. The state is committed: later masking of cur_id does not retract interrupt.
  - SERVICE: on write_strobe with port_id==PORT_EOI, go to IDLE. Events arriving meanwhile only pend. The earliest re-assert is the edge after the EOI edge.
  - interrupt_ack outside ASSERT is ignored.
- Simultaneous events:
  - event_in[cur_id] in the same cycle as its ack-clear: the set wins, pending stays 1, no overflow.
  - Multiple events in one cycle: all pend; priority resolves.
  - OVF write-1-to-clear coinciding with a new overflow on the same bit: the set wins.
- Register writes (write_strobe, full 8-bit port_id compare):
  - PORT_MASK: mask<=out_port[NUM_SRC-1:0].
  - PORT_OVF: ovf<=ovf & ~out_port[NUM_SRC-1:0].
  - PORT_EOI: handled as above.
  - Writes to other ports are ignored.
- Reads:
  - rd_data is registered; it is valid one cycle after port_id, independent of read_strobe, matching the pipelined input mux.
  - PORT_STATUS returns {irq_active, |eligible, 3'b0, cur_id[2:0]}.
  - PORT_MASK and PORT_OVF return the value zero-extended.
  - Any other port returns 8'h00.
- Widths: cur_id is 3 bits; unused high bits of mask and ovf read as 0.

Optional Feature:
- Macro: PICO_IRQ_ROUND_ROBIN_EN.
- Defined: priority rotates. The search starts at (last_serviced_id+1) mod NUM_SRC; last_serviced_id updates on ack and resets to NUM_SRC-1, so the first search starts at 0.
- Undefined: fixed lowest-index priority; there is no last_serviced register.

Decomposition:
- Package picoblaze_irq_pkg holds:
  - the FSM state enum (IDLE/ASSERT/SERVICE);
  - default port-address constants;
  - ID_W=3 and the MAX_SRC=8 constant.
- Sub-module picoblaze_irq_prio_sel: combinational find-first-set over NUM_SRC with a start-index input. The start index is tied to 0 when PICO_IRQ_ROUND_ROBIN_EN is undefined.

Test Plan:
1. Reset, then pulse event_in=4'b0100 -> interrupt high 2 cycles later; reading 8'h01 gives 8'h82; ack -> interrupt low, pending[2]=0.
2. Pulse event_in=4'b1010 together -> cur_id=1 serviced first; after EOI write, interrupt reasserts next cycle with cur_id=3.
3. Write 8'h0E to mask port, pulse event 0 -> no interrupt, status bit6=0; write 8'h0F -> interrupt asserts 2 cycles later with cur_id=0.
4. Pulse event 1 twice before ack -> reading 8'h08 gives 8'h02; write 8'h02 to 8'h08 -> reads 8'h00.
5. Pulse event 2 on the same cycle as ack of source 2 -> pending[2] remains 1, ovf[2]=0, source 2 reasserts after EOI.
6. With PICO_IRQ_ROUND_ROBIN_EN, hold all four pending continuously -> service order 0,1,2,3,0. Assert reset in SERVICE -> interrupt=0, mask=4'hF, status reads 8'h00.
